// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned FLAGS_W  = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/arithmetic_logic_unit.sv
// N-bit ALU: 00 add, 01 subtract, 10 AND, 11 OR; flags {negative, zero, carry_out, overflow}.
module arithmetic_logic_unit
  import alu_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]          a_i,
  input  logic [N-1:0]          b_i,
  input  logic [ALU_OP_W-1:0]   alu_control_i,
  output logic [N-1:0]          result_o,
  output logic [FLAGS_W-1:0]    flags_o
);

  logic [N-1:0] b_mux;
  logic [N:0]   sum;

  always_comb begin
    b_mux = alu_control_i[0] ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_mux} + {{N{1'b0}}, alu_control_i[0]};
    case (alu_control_i)
      2'b10:   result_o = a_i & b_i;
      2'b11:   result_o = a_i | b_i;
      default: result_o = sum[N-1:0];
    endcase
  end

  // Carry and overflow only mean something for add/subtract.
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_N] = result_o[N-1];
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_C] = ~alu_control_i[1] & sum[N];
    flags_o[FLAG_V] = ~alu_control_i[1]
                    & ~(a_i[N-1] ^ b_i[N-1] ^ alu_control_i[0])
                    & (a_i[N-1] ^ sum[N-1]);
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only on an accepted grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant
);

  // Reset value 1 means requester 0 wins the first contested round.
  logic last_q;

  always_comb begin
    grant = '0;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin fairness.
// Define ALU_ARB_STATS_EN to add per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N = 8
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [N-1:0]        req_a0,
  input  logic [N-1:0]        req_b0,
  input  logic [ALU_OP_W-1:0] req_op0,
  input  logic [N-1:0]        req_a1,
  input  logic [N-1:0]        req_b1,
  input  logic [ALU_OP_W-1:0] req_op1,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [N-1:0]        rsp_result,
  output logic [FLAGS_W-1:0]  rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1
`endif
);

  state_e              state_q;
  logic [N-1:0]        a_q, b_q;
  logic [ALU_OP_W-1:0] op_q;
  logic                id_q;
  logic                rsp_valid_q, rsp_id_q;
  logic [N-1:0]        rsp_result_q;
  logic [FLAGS_W-1:0]  rsp_flags_q;

  logic [1:0]          grant;
  logic                accept;
  logic [N-1:0]        alu_result;
  logic [FLAGS_W-1:0]  alu_flags;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .en     (state_q == IDLE),
    .accept (accept),
    .grant  (grant)
  );

  // A grant is only ever issued to a valid requester, so any grant is a handshake.
  assign accept    = |grant;
  assign req_ready = grant;

  arithmetic_logic_unit #(.N(N)) u_alu (
    .a_i           (a_q),
    .b_i           (b_q),
    .alu_control_i (op_q),
    .result_o      (alu_result),
    .flags_o       (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= grant[1] ? req_a1  : req_a0;
            b_q     <= grant[1] ? req_b1  : req_b0;
            op_q    <= grant[1] ? req_op1 : req_op0;
            id_q    <= grant[1];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant[0]) cnt0_q <= cnt0_q + 1'b1;
      if (grant[1]) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] req_op0, req_op1;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic last_id;
  int cnt0, cnt1;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N(8)
`ifdef ALU_ARB_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Reference ALU from plain integer arithmetic: 0 add, 1 sub, 2 and, 3 or.
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                                  output logic [7:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, u, s;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; u = 0; s = 0;
    case (op)
      2'd0: begin u = ua + ub; s = sa + sb; r = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128); end
      2'd1: begin u = ua - ub; s = sa - sb; r = u[7:0]; c = (ua >= ub); v = (s > 127) || (s < -128); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
    end
  endtask

  // Drives one offered request set, checks the grant, latency, response and backpressure.
  // Returns inside the RESP cycle where rsp_ready is high, valids still held.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1,
                       input int stall, input bit poke1, input string name);
    logic       exp_id;
    logic [1:0] exp_ready;
    logic [7:0] er;
    logic [3:0] ef;
    int         waited;
    @(negedge clk);
    req_valid = {v1, v0};
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
    rsp_ready = (stall == 0);
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    n_tests++;
    if (waited != 0) begin
      n_fail++;
      $display("FAIL %s grant_latency: waited %0d cycles, expected 0", name, waited);
    end
    if (req_ready == 2'b00) begin
      n_fail++;
      $display("FAIL %s no_grant: req_ready %b, expected a grant", name, req_ready);
      return;
    end
    exp_id    = (v0 && v1) ? ~last_id : v1;
    exp_ready = exp_id ? 2'b10 : 2'b01;
    n_tests++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL %s grant: req_ready %b, expected %b", name, req_ready, exp_ready);
    end
    last_id = exp_id;
    if (exp_id) cnt1++; else cnt0++;
    if (exp_id) ref_alu(a1, b1, op1, er, ef);
    else        ref_alu(a0, b0, op0, er, ef);

    @(negedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL %s exec_cycle: rsp_valid %b req_ready %b, expected 0 00", name, rsp_valid, req_ready);
    end

    @(negedge clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== er || rsp_flags !== ef) begin
      n_fail++;
      $display("FAIL %s response: valid %b id %b result %h flags %b, expected 1 %b %h %b",
               name, rsp_valid, rsp_id, rsp_result, rsp_flags, exp_id, er, ef);
    end

    for (int i = 0; i < stall; i++) begin
      if (poke1 && i == 0) begin
        req_valid[1] = 1'b1;
        #1;
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== er ||
          rsp_flags !== ef || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL %s stall%0d: valid %b id %b result %h flags %b ready %b, expected 1 %b %h %b 00",
                 name, i, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, exp_id, er, ef);
      end
      @(negedge clk);
      if (poke1 && i == 0) req_valid[1] = v1;
      #1;
    end

    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: req_ready %b rsp_valid %b, expected 00 1", name, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0; req_a1 = '0; req_b1 = '0; req_op1 = '0;
    @(negedge clk);
    @(negedge clk); #1;
    n_tests++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 ||
        rsp_result !== 8'h00 || rsp_flags !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready %b valid %b id %b result %h flags %b, expected 00 0 0 00 0000",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
`ifdef ALU_ARB_STATS_EN
    n_tests++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: %0d %0d, expected 0 0", grant_cnt0, grant_cnt1);
    end
`endif
    reset = 1'b0;
    last_id = 1'b1;
    cnt0 = 0; cnt1 = 0;
  endtask

  task automatic test_mid_exec_reset();
    @(negedge clk);
    req_valid = 2'b01; req_a0 = 8'h12; req_b0 = 8'h34; req_op0 = 2'd0; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_grant: req_ready %b, expected 01", req_ready);
    end
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b11;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_idle: rsp_valid %b req_ready %b, expected 0 01", rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale%0d: rsp_valid %b, expected 0", i, rsp_valid);
      end
    end
    last_id = 1'b1;
    cnt0 = 0; cnt1 = 0;
  endtask

  task automatic test_single_op();
    do_op(1'b1, 1'b0, 8'h7F, 8'h01, 2'd0, 8'h00, 8'h00, 2'd0, 0, 1'b0, "single_add");
    n_tests++;
    if (rsp_result !== 8'h80 || rsp_flags !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_add_const: result %h flags %b, expected 80 1001", rsp_result, rsp_flags);
    end
    idle_cycles(2);
  endtask

  task automatic test_alternate();
    logic [1:0] ids [4];
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b1, 8'(10 + i), 8'h03, 2'd0, 8'(20 + i), 8'h05, 2'd1, 0, 1'b0, "alternate");
      ids[i] = {1'b0, rsp_id};
    end
    idle_cycles(2);
    n_tests++;
    if (ids[0] != 2'd0 || ids[1] != 2'd1 || ids[2] != 2'd0 || ids[3] != 2'd1) begin
      n_fail++;
      $display("FAIL alternate_order: %0d%0d%0d%0d, expected 0101", ids[0], ids[1], ids[2], ids[3]);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 1'b1, 8'hF0, 8'h20, 2'd0, 8'hC3, 8'h0F, 2'd2, 5, 1'b0, "backpressure");
    do_op(1'b1, 1'b0, 8'hA5, 8'h5A, 2'd3, 8'hC3, 8'h0F, 2'd2, 0, 1'b0, "after_backpressure");
    idle_cycles(1);
  endtask

  task automatic test_zero_flag();
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 8'h55, 8'h55, 2'd1, 0, 1'b0, "zero_sub");
    n_tests++;
    if (rsp_result !== 8'h00 || rsp_flags[2] !== 1'b1 || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_sub_const: result %h Z %b id %b, expected 00 1 1", rsp_result, rsp_flags[2], rsp_id);
    end
    idle_cycles(1);
  endtask

  task automatic test_withdrawn();
    do_op(1'b1, 1'b0, 8'h01, 8'h02, 2'd0, 8'h99, 8'h11, 2'd1, 3, 1'b1, "withdraw_resp");
    do_op(1'b1, 1'b0, 8'h40, 8'h40, 2'd0, 8'h99, 8'h11, 2'd1, 0, 1'b0, "withdraw_next0");
    do_op(1'b1, 1'b1, 8'h0F, 8'hF0, 2'd3, 8'h80, 8'h80, 2'd0, 0, 1'b0, "withdraw_both");
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic [1:0] v;
    for (int i = 0; i < 24; i++) begin
      v = 2'($urandom_range(1, 3));
      do_op(v[0], v[1],
            8'($urandom), 8'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), 2'($urandom),
            int'($urandom_range(0, 3)), 1'b0, "random");
      if ($urandom_range(0, 1) == 0) idle_cycles(1);
    end
    idle_cycles(1);
  endtask

  task automatic test_stats();
`ifdef ALU_ARB_STATS_EN
    #1;
    n_tests++;
    if (grant_cnt0 !== 16'(cnt0) || grant_cnt1 !== 16'(cnt1)) begin
      n_fail++;
      $display("FAIL grant_counters: %0d %0d, expected %0d %0d", grant_cnt0, grant_cnt1, cnt0, cnt1);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    test_reset();
    test_mid_exec_reset();
    test_single_op();
    test_reset();
    test_alternate();
    test_stats();
    test_back_to_back();
    test_zero_flag();
    test_withdrawn();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
